// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// State codes, access size codes and the default watchdog limit.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned DEF_TIMEOUT = 64;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter that flags a memory access as hung.
// expire_o is high in the last BUSY cycle allowed without an ack.
module mem_arb_watchdog
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic busy_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i || ack_i || !busy_i) begin
      cnt_d = '0;
    end else if (!expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire_o = busy_i && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port memory.
// One access in flight; data wins ties unless fetch has waited too long.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = (MAX_D_STREAK > 0) ?
                      $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_e        state_q;
  logic [SW-1:0]     streak_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [1:0]        mem_size_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              i_ack_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic              i_err_q;
  logic              d_ack_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              d_err_q;

  logic idle;
  logic busy;
  logic grant_i;
  logic grant_d;
  logic expire;

  assign idle = (state_q == ST_IDLE);
  assign busy = (state_q == ST_BUSY_I) ||
                (state_q == ST_BUSY_D);

  // Fetch only beats a pending data request once its streak is exhausted.
  assign grant_i = i_req &&
                   (!d_req ||
                    ((MAX_D_STREAK != 0) &&
                     (streak_q == STREAK_MAX)));
  assign grant_d = d_req && !grant_i;

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .start_i (idle && (i_req || d_req)),
    .busy_i  (busy),
    .ack_i   (busy && mem_ack),
    .expire_o(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      i_err_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_i) begin
            state_q     <= ST_BUSY_I;
            streak_q    <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_size_q  <= SZ_WORD;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= '0;
          end else if (grant_d) begin
            state_q     <= ST_BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_size_q  <= d_size;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            if (!i_req) begin
              streak_q <= '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_q <= streak_q + 1'b1;
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (mem_ack || expire) begin
            state_q   <= ST_RESP;
            mem_req_q <= 1'b0;
            if (state_q == ST_BUSY_I) begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= mem_ack ? mem_rdata : '0;
              i_err_q   <= !mem_ack;
            end else begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= mem_ack ? mem_rdata : '0;
              d_err_q   <= !mem_ack;
            end
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign i_err     = i_err_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter with a latency-programmable memory.
// Expected completions are queued at stimulus time and popped on each ack.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mem_lat = 0;
  int   busy_cnt = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .MAX_D_STREAK(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'h00500093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory: acks on the mem_lat-th cycle (0-based) of a request; <0 never.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      if (mem_lat >= 0 && busy_cnt == mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_fn(mem_addr);
        busy_cnt  = 0;
      end else begin
        busy_cnt++;
      end
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_size = 2'b10;
    d_addr = 0; d_wdata = 0;
    mem_lat = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 1; i_addr = 32'h44;
    d_req = 1; d_addr = 32'h88;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got req=%b iack=%b dack=%b want 0 0 0",
               mem_req, i_ack, d_ack);
    end
    checks++;
    if ({mem_we, mem_size, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem_fields got we=%b sz=%b a=%h wd=%h want 0",
               mem_we, mem_size, mem_addr, mem_wdata);
    end
    checks++;
    if ({i_rdata, i_err, d_rdata, d_err} !== '0) begin
      errors++;
      $display("FAIL reset_resp got ird=%h ie=%b drd=%h de=%b want 0",
               i_rdata, i_err, d_rdata, d_err);
    end
    i_req = 0; d_req = 0;
  endtask

  task automatic test_zero_wait_fetch();
    exp_t e;
    reset_dut();
    mem_lat = 0;
    i_req = 1; i_addr = 32'h10;
    sb.push_back('{0, 32'h00500093, 1'b0});
    sb.push_back('{0, mem_fn(32'h20), 1'b0});
    @(negedge clk);
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h10 ||
        mem_we !== 0 || mem_size !== 2'b10) begin
      errors++;
      $display("FAIL zw_mem_c1 got req=%b a=%h we=%b sz=%b want 1 10 0 10",
               mem_req, mem_addr, mem_we, mem_size);
    end
    @(negedge clk);
    checks++;
    if (i_ack !== 1 || d_ack !== 0 || mem_req !== 0) begin
      errors++;
      $display("FAIL zw_ack_c2 got iack=%b dack=%b req=%b want 1 0 0",
               i_ack, d_ack, mem_req);
    end else begin
      e = sb.pop_front();
      checks++;
      if (i_rdata !== e.rdata || i_err !== e.err) begin
        errors++;
        $display("FAIL zw_rdata got %h err=%b want %h err=%b",
                 i_rdata, i_err, e.rdata, e.err);
      end
    end
    i_addr = 32'h20;
    @(negedge clk);
    checks++;
    if (mem_req !== 0 || i_ack !== 0) begin
      errors++;
      $display("FAIL zw_idle_c3 got req=%b iack=%b want 0 0",
               mem_req, i_ack);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h20) begin
      errors++;
      $display("FAIL zw_regrant_c4 got req=%b a=%h want 1 20",
               mem_req, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (i_ack !== 1) begin
      errors++;
      $display("FAIL zw_ack2_c5 got iack=%b want 1", i_ack);
    end else begin
      e = sb.pop_front();
      checks++;
      if (i_rdata !== e.rdata || i_err !== e.err) begin
        errors++;
        $display("FAIL zw_rdata2 got %h err=%b want %h err=%b",
                 i_rdata, i_err, e.rdata, e.err);
      end
    end
    i_req = 0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int   acks = 0;
    int   d_cyc = -1;
    int   i_cyc = -1;
    reset_dut();
    i_req = 1; i_addr = 32'h30;
    d_req = 1; d_we = 1; d_size = 2'b00;
    d_addr = 32'h204; d_wdata = 32'hAB;
    sb.push_back('{1, mem_fn(32'h204), 1'b0});
    sb.push_back('{0, mem_fn(32'h30), 1'b0});
    @(negedge clk);
    checks++;
    if (mem_req !== 1 || mem_we !== 1 || mem_size !== 2'b00 ||
        mem_addr !== 32'h204 || mem_wdata !== 32'hAB) begin
      errors++;
      $display("FAIL sim_dgrant got req=%b we=%b sz=%b a=%h wd=%h want 1 1 00 204 ab",
               mem_req, mem_we, mem_size, mem_addr, mem_wdata);
    end
    for (int c = 1; c < 20 && acks < 2; c++) begin
      if (c > 1) @(negedge clk);
      if (i_ack || d_ack) begin
        e = sb.pop_front();
        acks++;
        checks++;
        if ((i_ack && d_ack) || bit'(d_ack) != e.is_d ||
            (d_ack ? d_rdata : i_rdata) !== e.rdata ||
            (d_ack ? d_err : i_err) !== e.err) begin
          errors++;
          $display("FAIL sim_ack%0d got d=%b i=%b rd=%h want d=%b rd=%h",
                   acks, d_ack, i_ack, d_ack ? d_rdata : i_rdata,
                   e.is_d, e.rdata);
        end
        if (d_ack) begin d_cyc = c; d_req = 0; end
        if (i_ack) begin i_cyc = c; i_req = 0; end
      end
    end
    checks++;
    if (acks != 2 || i_cyc - d_cyc != 3) begin
      errors++;
      $display("FAIL sim_order got acks=%0d gap=%0d want 2 3",
               acks, i_cyc - d_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    exp_t e;
    int   acks = 0;
    int   di = 0;
    int   ii = 0;
    bit   order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      if (order[k]) begin
        sb.push_back('{1, mem_fn(32'h100 + 32'(4 * di)), 1'b0});
        di++;
      end else begin
        sb.push_back('{0, mem_fn(32'h40 + 32'(4 * ii)), 1'b0});
        ii++;
      end
    end
    di = 0; ii = 0;
    d_we = 0; d_size = 2'b10;
    d_addr = 32'h100; i_addr = 32'h40;
    i_req = 1; d_req = 1;
    for (int c = 0; c < 100 && acks < 10; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        e = sb.pop_front();
        checks++;
        if ((i_ack && d_ack) || bit'(d_ack) != e.is_d ||
            (d_ack ? d_rdata : i_rdata) !== e.rdata ||
            (d_ack ? d_err : i_err) !== e.err) begin
          errors++;
          $display("FAIL fair_grant%0d got d=%b i=%b rd=%h want d=%b rd=%h",
                   acks, d_ack, i_ack, d_ack ? d_rdata : i_rdata,
                   e.is_d, e.rdata);
        end
        acks++;
        if (d_ack) begin di++; d_addr = 32'h100 + 32'(4 * di); end
        if (i_ack) begin ii++; i_addr = 32'h40 + 32'(4 * ii); end
      end
    end
    checks++;
    if (acks != 10) begin
      errors++;
      $display("FAIL fair_budget got acks=%0d want 10", acks);
    end
    i_req = 0; d_req = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout(input int lat, input string nm);
    exp_t e;
    int   n = 0;
    bit   done = 0;
    reset_dut();
    mem_lat = 0;
    d_req = 1; d_we = 0; d_addr = 32'h310;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (d_ack) done = 1;
    end
    d_req = 0;
    @(negedge clk);
    mem_lat = lat;
    d_req = 1; d_addr = 32'h300;
    if (lat < 0) sb.push_back('{1, 32'h0, 1'b1});
    else sb.push_back('{1, mem_fn(32'h300), 1'b0});
    done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (mem_req) n++;
      if (d_ack) begin
        e = sb.pop_front();
        done = 1;
        checks++;
        if (d_rdata !== e.rdata || d_err !== e.err || i_ack !== 0) begin
          errors++;
          $display("FAIL %s_resp got rd=%h err=%b iack=%b want rd=%h err=%b",
                   nm, d_rdata, d_err, i_ack, e.rdata, e.err);
        end
      end
    end
    checks++;
    if (!done || n != 8) begin
      errors++;
      $display("FAIL %s_len got done=%b busy=%0d want 1 8", nm, done, n);
    end
    d_req = 0;
    mem_lat = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen = 0;
    reset_dut();
    mem_lat = -1;
    i_req = 1; i_addr = 32'h50;
    @(negedge clk);
    checks++;
    if (mem_req !== 1) begin
      errors++;
      $display("FAIL rmid_busy got req=%b want 1", mem_req);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 0) begin
      errors++;
      $display("FAIL rmid_async got req=%b want 0", mem_req);
    end
    mem_lat = 0;
    sb.push_back('{0, mem_fn(32'h50), 1'b0});
    @(negedge clk);
    if (i_ack) seen = 1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h50 || i_ack !== 0 || seen) begin
      errors++;
      $display("FAIL rmid_regrant got req=%b a=%h iack=%b early=%b want 1 50 0 0",
               mem_req, mem_addr, i_ack, seen);
    end
    @(negedge clk);
    checks++;
    if (i_ack !== 1) begin
      errors++;
      $display("FAIL rmid_ack got iack=%b want 1", i_ack);
    end else begin
      e = sb.pop_front();
      checks++;
      if (i_rdata !== e.rdata || i_err !== e.err) begin
        errors++;
        $display("FAIL rmid_rdata got %h err=%b want %h err=%b",
                 i_rdata, i_err, e.rdata, e.err);
      end
    end
    i_req = 0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_size = 0;
    d_addr = 0; d_wdata = 0;
    test_reset();
    test_zero_wait_fetch();
    test_simultaneous();
    test_fairness();
    test_timeout(-1, "timeout");
    test_timeout(7, "ack_race");
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the CPU's fetch stage (I port) and load/store stage (D port).
- Grants one outstanding access at a time, forwards it to the memory, and returns a registered acknowledge to the winning requester.
- Enforces fairness so that fetch cannot be starved by data accesses.
- Enforces a watchdog so that a hung memory cannot stall the CPU forever.
- Sits between the CPU core and the memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, cycles in BUSY without mem_ack before the access is aborted with an error (must be ≥1).
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch is waiting; 0 means pure data priority (no fairness).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_rdata  out  DATA_W  fetch data; valid with i_ack.
- i_err  out  1  fetch timed out; valid with i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store.
- d_size  in  2  00 byte, 01 half, 10 word.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_W  load data; valid with d_ack.
- d_err  out  1  data timed out; valid with d_ack.
- mem_req  out  1  memory access strobe; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_size  out  2  access size.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion; may arrive in the first mem_req cycle.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.

Behaviour:
- Reset values:
  - All outputs are 0; state is IDLE.
  - Streak and timeout counters are 0.
  - Reset mid-access abandons it: mem_req drops asynchronously and no ack is issued. The memory tolerates a withdrawn request.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, grant decision (made at the clock edge):
  - Only d_req → BUSY_D.
  - Only i_req → BUSY_I.
  - Both pending → BUSY_I if MAX_D_STREAK≠0 and streak==MAX_D_STREAK; otherwise BUSY_D.
  - At grant, the winner's addr/wdata/we/size are latched into the mem_* registers. Fetch always drives we=0, size=10.
- Streak counter:
  - On a D grant with i_req high, streak increments, saturating at MAX_D_STREAK.
  - On a D grant with i_req low, or on any I grant, streak clears.
- BUSY_x:
  - mem_req=1 with the latched fields stable.
  - The timeout counter increments every cycle.
  - When mem_ack is sampled: capture mem_rdata, go to RESP, clear mem_req.
  - If the counter reaches TIMEOUT without mem_ack: go to RESP with err=1 and rdata=0, clear mem_req.
  - A mem_ack arriving on the same edge as the timeout wins (normal completion, err=0).
- RESP:
  - Exactly one of i_ack/d_ack is 1 for one cycle, with its rdata/err. No grant is made in RESP.
  - The requester may change or drop req in the cycle after ack; the next state is always IDLE.
- Latency: req sampled at edge 0 → mem_req high in cycle 1 → with zero-wait memory, ack in cycle 2 → IDLE in cycle 3 → next grant at the end of cycle 3. Minimum throughput is one access per 3 cycles.
- Rules:
  - Requesters do not withdraw a request before ack; behaviour if they do is undefined.
  - rdata/err outputs hold their last value outside the ack cycle.
  - The timeout counter clears on entry to BUSY.

Decomposition:
- Shared package riscv_mem_pkg:
  - State encoding (2-bit).
  - Size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - Default TIMEOUT constant.
- One natural sub-module, mem_arb_watchdog: the loadable timeout counter, with start, ack and expire signals.
- The grant logic and streak counter stay inline.

Test Plan:
- Zero-wait fetch: i_req=1, i_addr=0x10; mem_ack=1 with rdata 0x00500093 in cycle 1 → mem_addr=0x10, mem_we=0 in cycle 1 only; i_ack=1, i_rdata=0x00500093, i_err=0 in cycle 2; state IDLE in cycle 3.
- Simultaneous requests, streak=0: i_req and d_req both set, d_we=1, d_size=00, d_addr=0x204, d_wdata=0xAB → D granted first with mem_we=1, mem_size=00; fetch is granted right after d_ack.
- Fairness: MAX_D_STREAK=4, both requesters re-request continuously → grant order D,D,D,D,I,D,D,D,D,I.
- Timeout: TIMEOUT=8, D load, mem_ack never asserted → mem_req high for exactly 8 cycles; d_ack=1, d_err=1, d_rdata=0 in the next cycle.
- Ack racing timeout: TIMEOUT=8, mem_ack on the 8th BUSY cycle → d_err=0 and rdata captured.
- Reset mid-access: rst asserted in the second BUSY_I cycle → mem_req=0 immediately; no i_ack; after release, a pending i_req is regranted from IDLE.
